// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// uart_pkg : shared UART state encoding and frame constants (TX and RX)
// Revision : 1.0
// ============================================================================
package uart_pkg;

  localparam int c_OVERSAMPLE  = 16;
  localparam int c_DATA_BITS   = 8;
  localparam int c_NIBBLE_BITS = 4;
  localparam int c_TICK_CNT_W  = 4;
  localparam int c_BIT_IDX_W   = 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  function automatic logic even_parity(input logic [c_DATA_BITS-1:0] b);
    return ^b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_bit_timer.sv
`default_nettype none
// ============================================================================
// uart_bit_timer : counts baud_tick strobes, strobes o_bit_end on the last one
// Revision : 1.0
// ============================================================================
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = c_OVERSAMPLE
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_baud_tick,
  output logic o_bit_end
);

  localparam logic [c_TICK_CNT_W-1:0] c_LAST_TICK = c_TICK_CNT_W'(OVERSAMPLE - 1);

  logic [c_TICK_CNT_W-1:0] r_tick_cnt;
  logic                    w_last_tick;

  assign w_last_tick = (r_tick_cnt == c_LAST_TICK);
  assign o_bit_end   = i_baud_tick & ~i_clear & w_last_tick;

  // Counter only moves on a strobe, so a stalled baud_tick freezes the bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tick_cnt <= '0;
    end else if (i_clear || o_bit_end) begin
      r_tick_cnt <= '0;
    end else if (i_baud_tick) begin
      r_tick_cnt <= r_tick_cnt + c_TICK_CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_transmitter.sv
`default_nettype none
// ============================================================================
// uart_transmitter : frames {address,data} LSB first; optional even parity
//                    bit when UART_TX_PARITY_EN is defined
// Revision : 1.0
// ============================================================================
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = c_OVERSAMPLE,
  parameter int STOP_BITS  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     baud_tick,
  input  logic                     send,
  input  logic [c_NIBBLE_BITS-1:0] address,
  input  logic [c_NIBBLE_BITS-1:0] data,
  output logic                     Tx,
  output logic                     busy,
  output logic                     done
);

  localparam logic [c_BIT_IDX_W-1:0] c_LAST_DATA = c_BIT_IDX_W'(c_DATA_BITS - 1);
  localparam logic [c_BIT_IDX_W-1:0] c_LAST_STOP = c_BIT_IDX_W'(STOP_BITS - 1);

  uart_state_e              r_state;
  uart_state_e              w_state_nxt;
  logic [c_DATA_BITS-1:0]   r_shift;
  logic [c_BIT_IDX_W-1:0]   r_bit_idx;
  logic                     r_armed;
  logic                     r_done;
  logic                     w_accept;
  logic                     w_bit_end;
  logic                     w_timer_clear;
`ifdef UART_TX_PARITY_EN
  logic                     r_parity;
`endif

  // r_armed blocks acceptance on the first edge after reset release.
  assign w_accept      = (r_state == IDLE) && send && r_armed;
  assign w_timer_clear = (r_state == IDLE);
  assign busy          = (r_state != IDLE);
  assign done          = r_done;

  uart_bit_timer #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_bit_timer (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (w_timer_clear),
    .i_baud_tick (baud_tick),
    .o_bit_end   (w_bit_end)
  );

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:   if (w_accept) w_state_nxt = START;
      START:  if (w_bit_end) w_state_nxt = DATA;
      DATA: begin
        if (w_bit_end && (r_bit_idx == c_LAST_DATA)) begin
`ifdef UART_TX_PARITY_EN
          w_state_nxt = PARITY;
`else
          w_state_nxt = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (w_bit_end) w_state_nxt = STOP;
`endif
      STOP:   if (w_bit_end && (r_bit_idx == c_LAST_STOP)) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    Tx = 1'b1;
    case (r_state)
      START:  Tx = 1'b0;
      DATA:   Tx = r_shift[0];
`ifdef UART_TX_PARITY_EN
      PARITY: Tx = r_parity;
`endif
      default: Tx = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Bit index counts data bits, then is reused to count stop periods.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_armed   <= 1'b0;
      r_done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      r_armed <= 1'b1;
      r_done  <= (r_state == STOP) && (w_state_nxt == IDLE);
      if (w_accept) begin
        r_shift   <= {address, data};
        r_bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
        r_parity  <= even_parity({address, data});
`endif
      end else if (w_bit_end) begin
        if (r_state == DATA) begin
          r_shift <= {1'b0, r_shift[c_DATA_BITS-1:1]};
        end
        if ((r_state == DATA) || (r_state == STOP)) begin
          r_bit_idx <= (w_state_nxt == IDLE) ? '0 : r_bit_idx + c_BIT_IDX_W'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_transmitter.sv
`default_nettype none
// ============================================================================
// tb_uart_transmitter : randomized scoreboard bench for uart_transmitter
// Revision : 1.0
// ============================================================================
module tb_uart_transmitter;

  localparam int OS        = 16;
  localparam int STOP_BITS = 2;
`ifdef UART_TX_PARITY_EN
  localparam int PAR_BITS  = 1;
`else
  localparam int PAR_BITS  = 0;
`endif
  localparam int FRAME_BITS = 1 + 8 + PAR_BITS + STOP_BITS;
  localparam int MAX_GAP    = 2;

  logic       clk;
  logic       rst;
  logic       baud_tick;
  logic       send;
  logic [3:0] address;
  logic [3:0] data;
  logic       tx;
  logic       busy;
  logic       done;

  int n_checks    = 0;
  int n_fail      = 0;
  int frames_done = 0;
  int frames_exp  = 0;
  int tick_total  = 0;
  int b2b_rises   = 0;
  bit tick_freeze = 0;
  bit b2b_mode    = 0;
  logic [7:0] exp_q[$];
  bit         trace[$];

  uart_transmitter #(
    .OVERSAMPLE (OS),
    .STOP_BITS  (STOP_BITS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .baud_tick (baud_tick),
    .send      (send),
    .address   (address),
    .data      (data),
    .Tx        (tx),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Reference frame: start 0, byte LSB first, optional even parity, stop ones.
  function automatic bit frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (PAR_BITS == 1 && k == 9) return ($countones(b) % 2) == 1;
    return 1'b1;
  endfunction

  // Irregular one-clk strobes; tick_total numbers every strobe issued.
  initial begin : tick_gen
    int gap;
    gap = 0;
    baud_tick = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (tick_freeze) begin
        baud_tick = 1'b0;
      end else if (gap != 0) begin
        baud_tick = 1'b0;
        gap--;
      end else begin
        baud_tick = 1'b1;
        tick_total++;
        gap = $urandom_range(0, MAX_GAP);
      end
    end
  end

  task automatic score_frame(input logic [7:0] b);
    int ones;
    check($sformatf("frame_%02h_len", b), trace.size(), FRAME_BITS * OS);
    for (int k = 0; k < FRAME_BITS; k++) begin
      ones = 0;
      for (int j = 0; j < OS; j++)
        if ((k * OS + j) < trace.size() && trace[k * OS + j]) ones++;
      check($sformatf("frame_%02h_bit%0d", b, k), ones, frame_bit(b, k) ? OS : 0);
    end
  endtask

  // Monitor: Tx seen at each counted strobe forms the trace; done closes it.
  initial begin : monitor
    bit prev_busy;
    bit prev_done;
    prev_busy = 1'b0;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        trace.delete();
        prev_busy = 1'b0;
        prev_done = 1'b0;
      end else begin
        if (busy && !prev_busy) begin
          check("start_bit_level", tx, 0);
          if (b2b_mode) begin
            if (b2b_rises > 0) check("b2b_start_after_done", prev_done, 1);
            b2b_rises++;
          end
          trace.delete();
        end
        if (busy && baud_tick) trace.push_back(tx);
        if (done) begin
          check("done_with_frame_pending", (exp_q.size() > 0) ? 1 : 0, 1);
          if (exp_q.size() > 0) score_frame(exp_q.pop_front());
          check("done_busy_clear", busy, 0);
          check("done_tx_high", tx, 1);
          frames_done++;
        end
        prev_busy = busy;
        prev_done = done;
      end
    end
  end

  task automatic send_frame(input logic [7:0] b, output int base);
    @(posedge clk); #1;
    address = b[7:4];
    data    = b[3:0];
    send    = 1'b1;
    exp_q.push_back(b);
    frames_exp++;
    @(negedge clk);
    base = tick_total;
    @(posedge clk); #1;
    send = 1'b0;
  endtask

  task automatic release_and_send(input logic [7:0] b);
    address = b[7:4];
    data    = b[3:0];
    send    = 1'b1;
    exp_q.push_back(b);
    frames_exp++;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("send_ignored_first_clk", busy, 0);
    @(posedge clk); #1;
    send = 1'b0;
    @(negedge clk);
    check("send_accepted_second_clk", busy, 1);
  endtask

  task automatic wait_ticks(input int base, input int n);
    int guard;
    guard = 0;
    while ((tick_total - base) < n && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    check("wait_ticks_timeout", ((tick_total - base) >= n) ? 1 : 0, 1);
  endtask

  task automatic wait_frames();
    int guard;
    guard = 0;
    while (frames_done < frames_exp && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    check("frame_complete_timeout", frames_done, frames_exp);
  endtask

  task automatic pulse_ignored(input logic [7:0] junk);
    @(posedge clk); #1;
    address = junk[7:4];
    data    = junk[3:0];
    send    = 1'b1;
    @(negedge clk);
    check("busy_held_on_ignored_send", busy, 1);
    @(posedge clk); #1;
    send = 1'b0;
  endtask

  initial begin : stim
    int         base;
    int         seen;
    int         guard;
    logic [7:0] b;
    rst     = 1'b0;
    send    = 1'b0;
    address = '0;
    data    = '0;
    repeat (2) @(negedge clk);
    check("reset_tx", tx, 1);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);

    release_and_send(8'($urandom));
    wait_frames();

    // address A, data 5 -> byte A5
    send_frame(8'hA5, base);
    wait_frames();
    send_frame(8'h01, base);
    wait_frames();

    b = 8'($urandom);
    if (b == 8'hFF) b = 8'h3C;
    send_frame(b, base);
    wait_ticks(base, 3 * OS + 5);
    pulse_ignored(8'hFF);
    wait_frames();

    // Strobes stall mid data bit 5 (frame bit 6)
    b = 8'($urandom);
    send_frame(b, base);
    wait_ticks(base, 6 * OS + 7);
    tick_freeze = 1'b1;
    repeat (100) @(negedge clk);
    check("frozen_tx", tx, frame_bit(b, 6));
    check("frozen_busy", busy, 1);
    tick_freeze = 1'b0;
    wait_frames();

    // Reset in the middle of data bit 3 (frame bit 4)
    b = 8'($urandom);
    send_frame(b, base);
    wait_ticks(base, 4 * OS + 8);
    check("pre_reset_data_bit3", tx, frame_bit(b, 4));
    #2;
    rst = 1'b0;
    void'(exp_q.pop_back());
    frames_exp--;
    #1;
    check("abort_tx", tx, 1);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    repeat (3) @(posedge clk);
    release_and_send(8'($urandom));
    wait_frames();

    // send held high: three back-to-back frames
    b = 8'($urandom);
    @(posedge clk); #1;
    address   = b[7:4];
    data      = b[3:0];
    b2b_rises = 0;
    b2b_mode  = 1'b1;
    send      = 1'b1;
    repeat (3) begin
      exp_q.push_back(b);
      frames_exp++;
    end
    seen  = 0;
    guard = 0;
    while (seen < 3 && guard < 10000) begin
      @(negedge clk);
      guard++;
      if (done) seen++;
    end
    send = 1'b0;
    check("b2b_done_count", seen, 3);
    wait_frames();
    b2b_mode = 1'b0;

    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom);
      send_frame(b, base);
      if ($urandom_range(0, 1) == 1) begin
        wait_ticks(base, $urandom_range(1, FRAME_BITS * OS - 2));
        pulse_ignored(8'($urandom));
      end
      wait_frames();
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1);
  end

endmodule
`default_nettype wire
